// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: frame sequencer for a WS2812 chain.
//   Holds one 24-bit GRB word per LED in a host-written pixel RAM. On a frame
//   trigger it streams the words in LED-index order to the bit serializer over
//   valid/ready, waits for the serializer to go idle, then enforces the latch
//   gap before signalling frame_done and accepting the next frame.
// Optional feature macro: WS2812_BRIGHTNESS_EN
//   Defined: each channel is scaled by brightness_i in an extra register stage.
//   Undefined: brightness_i is ignored and pixel words pass through unmodified.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en_i/addr/data pixel RAM write port (addresses >= LED_NUM ignored)
//   brightness_i      global channel scale (feature macro only)
//   frame_start_i     one-cycle frame trigger (queued once while busy)
//   busy_o            frame in progress
//   frame_done_o      one-cycle pulse at the end of the latch gap
//   pix_valid_o/pix_data_o/pix_ready_i  pixel handshake toward the serializer
//   ser_idle_i        serializer finished its last bit
module ws2812_frame_ctrl #(
  parameter int unsigned LED_NUM  = 2,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned CLK_FRE  = 27_000_000,
  parameter int unsigned RESET_US = 80
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [23:0]       wr_data_i,
  input  logic [7:0]        brightness_i,
  input  logic              frame_start_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              pix_valid_o,
  output logic [23:0]       pix_data_o,
  input  logic              pix_ready_i,
  input  logic              ser_idle_i
);

  localparam int unsigned LATCH_CYC = CLK_FRE / 1_000_000 * RESET_US;
  localparam int unsigned CNT_W     = $clog2(LATCH_CYC + 1);
  localparam int unsigned RAM_D     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LED_NUM_W = (ADDR_W + 1)'(LED_NUM);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LED_NUM - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LATCH_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SCALE,
    S_SEND,
    S_WAIT_IDLE,
    S_LATCH
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pending_q;
  logic [23:0]       ram_q [RAM_D];
  logic              wr_ok;

`ifdef WS2812_BRIGHTNESS_EN
  logic [23:0] raw_q;
  logic [7:0]  bri_q;

  // c' = (c * b) >> 8
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * 16'(b);
    return p[15:8];
  endfunction
`else
  logic unused_bri;
  assign unused_bri = ^brightness_i;
`endif

  // Pixel RAM: writes in any state, out-of-range addresses dropped, never reset.
  assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < LED_NUM_W);

  always_ff @(posedge clk) begin
    if (wr_ok) ram_q[wr_addr_i] <= wr_data_i;
  end

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      pix_valid_o  <= 1'b0;
      pix_data_o   <= '0;
`ifdef WS2812_BRIGHTNESS_EN
      raw_q        <= '0;
      bri_q        <= '0;
`endif
    end else begin
      frame_done_o <= 1'b0;
      // Any number of triggers during a frame collapse into one queued frame.
      if (frame_start_i && (state_q != S_IDLE)) pending_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (frame_start_i) begin
            state_q <= S_FETCH;
            idx_q   <= '0;
            busy_o  <= 1'b1;
          end
        end

        S_FETCH: begin
`ifdef WS2812_BRIGHTNESS_EN
          raw_q   <= ram_q[idx_q];
          bri_q   <= brightness_i;
          state_q <= S_SCALE;
`else
          pix_data_o  <= ram_q[idx_q];
          pix_valid_o <= 1'b1;
          state_q     <= S_SEND;
`endif
        end

        S_SCALE: begin
`ifdef WS2812_BRIGHTNESS_EN
          pix_data_o  <= {scale8(raw_q[23:16], bri_q),
                          scale8(raw_q[15:8],  bri_q),
                          scale8(raw_q[7:0],   bri_q)};
          pix_valid_o <= 1'b1;
          state_q     <= S_SEND;
`else
          state_q <= S_IDLE;
`endif
        end

        S_SEND: begin
          if (pix_ready_i) begin
            pix_valid_o <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= S_WAIT_IDLE;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= S_FETCH;
            end
          end
        end

        S_WAIT_IDLE: begin
          if (ser_idle_i) begin
            cnt_q   <= '0;
            state_q <= S_LATCH;
          end
        end

        S_LATCH: begin
          if (cnt_q == LAST_CNT) begin
            frame_done_o <= 1'b1;
            // A trigger on this final cycle is treated as already queued.
            if (pending_q || frame_start_i) begin
              pending_q <= 1'b0;
              idx_q     <= '0;
              state_q   <= S_FETCH;
            end else begin
              busy_o  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb_ws2812_frame_ctrl: self-checking bench for ws2812_frame_ctrl at default
// parameters (LED_NUM=2, latch gap 2160 cycles). Follows WS2812_BRIGHTNESS_EN.
`timescale 1ns/1ps
module tb_ws2812_frame_ctrl;

  localparam int LATCH_CYC = 2160;
`ifdef WS2812_BRIGHTNESS_EN
  localparam int VLAT = 3;
`else
  localparam int VLAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en_i;
  logic [3:0]  wr_addr_i;
  logic [23:0] wr_data_i;
  logic [7:0]  brightness_i;
  logic        frame_start_i;
  logic        busy_o;
  logic        frame_done_o;
  logic        pix_valid_o;
  logic [23:0] pix_data_o;
  logic        pix_ready_i;
  logic        ser_idle_i;

  int checks = 0;
  int errors = 0;

  ws2812_frame_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en_i       (wr_en_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .brightness_i  (brightness_i),
    .frame_start_i (frame_start_i),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .pix_valid_o   (pix_valid_o),
    .pix_data_o    (pix_data_o),
    .pix_ready_i   (pix_ready_i),
    .ser_idle_i    (ser_idle_i)
  );

  always #5 clk = ~clk;

  // d0/d1: RAM words; e*: expected unscaled output; s*: expected with scaling.
  typedef struct {
    logic [23:0] d0;
    logic [23:0] d1;
    bit          stray;
    logic [3:0]  saddr;
    logic [23:0] sdata;
    logic [7:0]  bri;
    logic [23:0] e0;
    logic [23:0] e1;
    logic [23:0] s0;
    logic [23:0] s1;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [23:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    tick();
    wr_en_i   = 1'b0;
  endtask

  function automatic logic [23:0] pick(input logic [23:0] plain, input logic [23:0] scaled);
`ifdef WS2812_BRIGHTNESS_EN
    logic [23:0] unused_plain;
    unused_plain = plain;
    return scaled;
`else
    logic [23:0] unused_scaled;
    unused_scaled = scaled;
    return plain;
`endif
  endfunction

  // Trigger a frame from IDLE and check busy and first-pixel latency.
  task automatic do_start();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    check("busy_rise", 32'(busy_o), 32'd1);
    for (int k = 1; k < VLAT; k++) begin
      check("valid_early", 32'(pix_valid_o), 32'd0);
      tick();
    end
    check("valid_latency", 32'(pix_valid_o), 32'd1);
  endtask

  // Hand both pixels over, optionally stalling pixel 0 and pulsing triggers meanwhile.
  task automatic send_pix(input logic [23:0] e0, input logic [23:0] e1,
                          input int bp, input int starts);
    int n;
    check("pix0_data", 32'(pix_data_o), 32'(e0));
    if (bp > 0) begin
      pix_ready_i = 1'b0;
      for (int k = 0; k < bp; k++) begin
        frame_start_i = (k < starts);
        tick();
        frame_start_i = 1'b0;
        check("bp_hold", 32'({pix_valid_o, pix_data_o}), 32'({1'b1, e0}));
      end
    end
    pix_ready_i = 1'b1;
    tick();
    check("hs0_drop", 32'(pix_valid_o), 32'd0);
    n = 0;
    while (!pix_valid_o && n < 20) begin
      tick();
      n++;
    end
    check("pix1_gap", 32'(n), 32'(VLAT - 1));
    check("pix1_data", 32'(pix_data_o), 32'(e1));
    tick();
    check("hs1_drop", 32'(pix_valid_o), 32'd0);
  endtask

  // Wait for ser_idle, then measure the latch gap up to frame_done.
  task automatic do_latch(input bit exp_pending, input bit start_at_end);
    int n;
    for (int k = 0; k < 3; k++) begin
      check("wait_idle_hold", 32'({busy_o, frame_done_o, pix_valid_o}), 32'b100);
      tick();
    end
    ser_idle_i = 1'b1;
    tick();
    ser_idle_i = 1'b0;
    n = 0;
    while (!frame_done_o && n < LATCH_CYC + 50) begin
      if (start_at_end && n == LATCH_CYC - 1) frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
      n++;
    end
    check("latch_len", 32'(n), 32'(LATCH_CYC));
    check("busy_at_done", 32'(busy_o), 32'(exp_pending));
  endtask

  task automatic idle_after();
    tick();
    check("idle_after", 32'({busy_o, frame_done_o, pix_valid_o}), 32'b000);
  endtask

  // Queued frame follows frame_done with no idle cycle.
  task automatic resume();
    check("resume_valid0", 32'(pix_valid_o), 32'd0);
    tick();
    check("resume_busy", 32'({busy_o, frame_done_o}), 32'b10);
    for (int k = 0; k < VLAT - 2; k++) tick();
    check("resume_valid", 32'(pix_valid_o), 32'd1);
  endtask

  logic [23:0] c0, c1, a_x, b_x;

  initial begin
    //          d0         d1         stray saddr sdata      bri    e0         e1         s0         s1
    vecs[0] = '{24'h00FF00, 24'h0000FF, 1'b1, 4'd5,  24'hFFFFFF, 8'h80, 24'h00FF00, 24'h0000FF, 24'h007F00, 24'h00007F};
    vecs[1] = '{24'h123456, 24'hABCDEF, 1'b1, 4'd2,  24'h000000, 8'hFF, 24'h123456, 24'hABCDEF, 24'h113355, 24'hAACCEE};
    vecs[2] = '{24'hFFFFFF, 24'h000000, 1'b1, 4'd15, 24'h5A5A5A, 8'h00, 24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000};
    vecs[3] = '{24'h800001, 24'h7FFFFE, 1'b0, 4'd0,  24'h000000, 8'h40, 24'h800001, 24'h7FFFFE, 24'h200000, 24'h1F3F3F};
    vecs[4] = '{24'hFF0080, 24'h102030, 1'b0, 4'd0,  24'h000000, 8'h80, 24'hFF0080, 24'h102030, 24'h7F0040, 24'h081018};

    rst = 1'b1;
    wr_en_i = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    brightness_i = '0;
    frame_start_i = 1'b0;
    pix_ready_i = 1'b1;
    ser_idle_i = 1'b0;
    tick();
    tick();
    check("reset_outs", 32'({busy_o, frame_done_o, pix_valid_o, pix_data_o}), 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_idle", 32'({busy_o, frame_done_o, pix_valid_o}), 32'b000);

    // Table-driven frames, each with an optional out-of-range write after the valid ones.
    for (int i = 0; i < 5; i++) begin
      wr(4'd0, vecs[i].d0);
      wr(4'd1, vecs[i].d1);
      if (vecs[i].stray) wr(vecs[i].saddr, vecs[i].sdata);
      brightness_i = vecs[i].bri;
      do_start();
      send_pix(pick(vecs[i].e0, vecs[i].s0), pick(vecs[i].e1, vecs[i].s1), 0, 0);
      do_latch(1'b0, 1'b0);
      idle_after();
    end

    c0 = pick(vecs[4].e0, vecs[4].s0);
    c1 = pick(vecs[4].e1, vecs[4].s1);

    // Backpressure for 10 cycles on pixel 0.
    do_start();
    send_pix(c0, c1, 10, 0);
    do_latch(1'b0, 1'b0);
    idle_after();

    // Three triggers during a frame give exactly one back-to-back extra frame.
    do_start();
    send_pix(c0, c1, 5, 3);
    do_latch(1'b1, 1'b0);
    resume();
    send_pix(c0, c1, 0, 0);
    do_latch(1'b0, 1'b0);
    idle_after();
    for (int k = 0; k < 5; k++) tick();
    check("no_third_frame", 32'({busy_o, pix_valid_o}), 32'b00);

    // Trigger on the final latch cycle counts as pending.
    do_start();
    send_pix(c0, c1, 0, 0);
    do_latch(1'b1, 1'b1);
    resume();
    send_pix(c0, c1, 0, 0);
    do_latch(1'b0, 1'b0);
    idle_after();

    // Writes mid-frame: fetched pixel keeps its value, unfetched one takes the new one.
    a_x = pick(24'hFFFFFF, 24'h7F7F7F);
    b_x = pick(24'h020406, 24'h010203);
    do_start();
    pix_ready_i = 1'b0;
    wr(4'd0, 24'hFFFFFF);
    wr(4'd1, 24'h020406);
    check("fetched_kept", 32'({pix_valid_o, pix_data_o}), 32'({1'b1, c0}));
    pix_ready_i = 1'b1;
    tick();
    for (int k = 0; k < 20 && !pix_valid_o; k++) tick();
    check("unfetched_new", 32'({pix_valid_o, pix_data_o}), 32'({1'b1, b_x}));
    tick();
    do_latch(1'b0, 1'b0);
    idle_after();

    // Asynchronous reset while pix_valid is high, then replay of RAM.
    do_start();
    pix_ready_i = 1'b0;
    tick();
    check("pre_reset_valid", 32'(pix_valid_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'({busy_o, frame_done_o, pix_valid_o, pix_data_o}), 32'd0);
    tick();
    rst = 1'b0;
    pix_ready_i = 1'b1;
    tick();
    check("reset_idle", 32'({busy_o, pix_valid_o}), 32'b00);
    do_start();
    send_pix(a_x, b_x, 0, 0);
    do_latch(1'b0, 1'b0);
    idle_after();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
